// File: rtl/cal_abs_phase_mf.sv
// rtl/cal_abs_phase_mf.sv - multi-frequency absolute phase unwrapping over packetised phase lanes
// Stage 0 seeds a per-beat buffer; each finer stage unwraps against the scaled buffer entry.
module cal_abs_phase_mf #(
  parameter int PHASE_NUM    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int FREQ_NUM     = 3,
  parameter int RATIO_LOG2   = 3,
  parameter int BUFFER_DEPTH = 512,
  localparam int ABS_WIDTH   = DATA_WIDTH + (FREQ_NUM - 1) * RATIO_LOG2
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [PHASE_NUM*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [PHASE_NUM*ABS_WIDTH-1:0]    m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              err_len
);

  localparam int AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int BW = $clog2(BUFFER_DEPTH + 1);
  localparam int SW = $clog2(FREQ_NUM);
  localparam int CW = ABS_WIDTH + RATIO_LOG2 + 2;
  localparam int MW = PHASE_NUM * ABS_WIDTH;
  localparam int IW = PHASE_NUM * DATA_WIDTH;
  localparam logic [SW-1:0] LAST_STAGE = SW'(FREQ_NUM - 1);

  logic          rdy_q, rdy_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [BW-1:0] len_q, len_d;
  logic          err_q, err_d;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_wr_q, s1_wr_d;
  logic          s1_out_q, s1_out_d;
  logic          s1_last_q, s1_last_d;
  logic [SW-1:0] s1_stage_q, s1_stage_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic [IW-1:0] s1_p_q, s1_p_d;

  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [MW-1:0] m_data_q, m_data_d;

  logic [MW-1:0] mem_q [BUFFER_DEPTH];
  logic [MW-1:0] buf_rd_q;

  logic          adv, accept;
  logic          first_stage, last_stage, in_depth, in_len, short_pkt;
  logic [BW-1:0] beat_inc;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] res;

  // Unwrap one lane: pick the 2pi multiple k that lands p closest to the scaled coarse estimate.
  function automatic logic [ABS_WIDTH-1:0] unwrap_lane(
    input logic [ABS_WIDTH-1:0]  prev,
    input logic [DATA_WIDTH-1:0] p,
    input logic [SW-1:0]         stage
  );
    logic signed [CW-1:0] prev_sh, p_s, diff, k, a, amax;
    prev_sh = signed'(CW'(prev)) <<< RATIO_LOG2;
    p_s     = signed'(CW'(p));
    diff    = prev_sh - p_s + signed'(CW'(1) << (DATA_WIDTH - 1));
    k       = diff >>> DATA_WIDTH;
    a       = (k <<< DATA_WIDTH) + p_s;
    amax    = signed'((CW'(1) << (DATA_WIDTH + int'(stage) * RATIO_LOG2)) - CW'(1));
    if (stage == '0) begin
      unwrap_lane = ABS_WIDTH'(p);
    end else if (a[CW-1]) begin
      unwrap_lane = '0;
    end else if (a > amax) begin
      unwrap_lane = amax[ABS_WIDTH-1:0];
    end else begin
      unwrap_lane = a[ABS_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    adv         = !m_valid_q || m_axis_tready;
    accept      = rdy_q && adv && s_axis_tvalid;
    first_stage = (stage_q == '0);
    last_stage  = (stage_q == LAST_STAGE);
    beat_inc    = beat_q + BW'(1);
    in_depth    = (beat_q < BW'(BUFFER_DEPTH));
    in_len      = (beat_q < len_q);
    short_pkt   = s_axis_tlast && in_len && (beat_inc < len_q);
    rd_addr     = beat_q[AW-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q      <= 1'b0;
      stage_q    <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_out_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_stage_q <= '0;
      s1_addr_q  <= '0;
      s1_p_q     <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
    end else begin
      rdy_q      <= rdy_d;
      stage_q    <= stage_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      err_q      <= err_d;
      s1_valid_q <= s1_valid_d;
      s1_wr_q    <= s1_wr_d;
      s1_out_q   <= s1_out_d;
      s1_last_q  <= s1_last_d;
      s1_stage_q <= s1_stage_d;
      s1_addr_q  <= s1_addr_d;
      s1_p_q     <= s1_p_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
    end
  end

  // Stage / beat / length bookkeeping; the beat counter saturates so an overlong packet never aliases.
  always_comb begin
    rdy_d   = 1'b1;
    stage_d = stage_q;
    beat_d  = beat_q;
    len_d   = len_q;
    err_d   = err_q;
    if (accept) begin
      if (first_stage) begin
        if (!in_depth) err_d = 1'b1;
        if (s_axis_tlast) len_d = in_depth ? beat_inc : BW'(BUFFER_DEPTH);
      end else if (!in_len || short_pkt) begin
        err_d = 1'b1;
      end
      if (s_axis_tlast) begin
        beat_d  = '0;
        stage_d = last_stage ? '0 : stage_q + SW'(1);
      end else if (beat_q != '1) begin
        beat_d = beat_inc;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_wr_d    = s1_wr_q;
    s1_out_d   = s1_out_q;
    s1_last_d  = s1_last_q;
    s1_stage_d = s1_stage_q;
    s1_addr_d  = s1_addr_q;
    s1_p_d     = s1_p_q;
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_wr_d    = first_stage ? in_depth : (in_len && !last_stage);
        s1_out_d   = last_stage && in_len;
        s1_last_d  = s_axis_tlast;
        s1_stage_d = stage_q;
        s1_addr_d  = rd_addr;
        s1_p_d     = s_axis_tdata;
      end
    end
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < PHASE_NUM; i++) begin
      res[i*ABS_WIDTH +: ABS_WIDTH] = unwrap_lane(buf_rd_q[i*ABS_WIDTH +: ABS_WIDTH],
                                                  s1_p_q[i*DATA_WIDTH +: DATA_WIDTH],
                                                  s1_stage_q);
    end
  end

  always_comb begin
    wr_en     = adv && s1_valid_q && s1_wr_q;
    wr_addr   = s1_addr_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (adv) begin
      m_valid_d = s1_valid_q && s1_out_q;
      m_last_d  = s1_valid_q && s1_out_q && s1_last_q;
      if (s1_valid_q && s1_out_q) m_data_d = res;
    end
  end

  // Read-first RAM; the bypass covers a one-beat packet whose write lands on the next packet's first read.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_addr] <= res;
    if (adv) buf_rd_q <= (wr_en && (wr_addr == rd_addr)) ? res : mem_q[rd_addr];
  end

  assign s_axis_tready = rdy_q && adv;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdata  = m_data_q;
  assign err_len       = err_q;

endmodule

// File: tb/tb_cal_abs_phase_mf.sv
// tb/tb_cal_abs_phase_mf.sv - self-checking bench for cal_abs_phase_mf
module tb_cal_abs_phase_mf;
  localparam int PN  = 8;
  localparam int DW  = 16;
  localparam int FN  = 3;
  localparam int RL  = 3;
  localparam int BD  = 512;
  localparam int AWD = DW + (FN - 1) * RL;

  typedef logic [PN*DW-1:0]  in_t;
  typedef logic [PN*AWD-1:0] out_t;
  typedef struct packed { logic last; out_t data; } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  in_t  s_tdata = '0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic s_tready;
  out_t m_tdata;
  logic m_tvalid, m_tlast;
  logic m_tready = 1'b1;
  logic err_len;

  int n_checks = 0;
  int n_fail = 0;
  int stab_err = 0;
  int rdy_err = 0;
  bit bp_en = 0;
  bit chk_ready = 0;
  bit prev_stall = 0;
  logic [PN*AWD+1:0] prev_vec = '0;
  beat_t got_q[$];
  beat_t exp_q[$];

  longint ref_buf[BD][PN];
  int m_stage = 0, m_beat = 0, m_len = 0;
  bit m_err = 0;

  always #5 aclk = ~aclk;

  cal_abs_phase_mf #(
    .PHASE_NUM(PN), .DATA_WIDTH(DW), .FREQ_NUM(FN), .RATIO_LOG2(RL), .BUFFER_DEPTH(BD)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .err_len(err_len)
  );

  initial begin
    forever begin
      @(negedge aclk);
      if (prev_stall && {m_tvalid, m_tlast, m_tdata} !== prev_vec) stab_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_vec   = {m_tvalid, m_tlast, m_tdata};
      if (chk_ready && s_tready !== (!m_tvalid || m_tready)) rdy_err++;
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Unwrap written as the plain arithmetic formula, with an explicit floor for negatives.
  function automatic longint ref_unwrap(longint prev, longint p, int s);
    longint full, num, k, a, mx;
    full = longint'(1) << DW;
    num  = prev * (longint'(1) << RL) - p + full / 2;
    k    = (num >= 0) ? num / full : -((-num + full - 1) / full);
    a    = p + k * full;
    mx   = (longint'(1) << (DW + s * RL)) - 1;
    if (a < 0) a = 0;
    if (a > mx) a = mx;
    return a;
  endfunction

  function automatic void model_beat(in_t d, logic last);
    out_t  o;
    beat_t e;
    longint p, a;
    o = '0;
    if (m_stage == 0) begin
      if (m_beat < BD) begin
        for (int l = 0; l < PN; l++) ref_buf[m_beat][l] = longint'(d[l*DW +: DW]);
      end else begin
        m_err = 1;
      end
      if (last) m_len = (m_beat + 1 > BD) ? BD : m_beat + 1;
    end else if (m_beat >= m_len) begin
      m_err = 1;
    end else begin
      for (int l = 0; l < PN; l++) begin
        p = longint'(d[l*DW +: DW]);
        a = ref_unwrap(ref_buf[m_beat][l], p, m_stage);
        if (m_stage == FN - 1) o[l*AWD +: AWD] = AWD'(a);
        else ref_buf[m_beat][l] = a;
      end
      if (m_stage == FN - 1) begin
        e.last = last;
        e.data = o;
        exp_q.push_back(e);
      end
      if (last && m_beat < m_len - 1) m_err = 1;
    end
    if (last) begin
      m_stage = (m_stage + 1) % FN;
      m_beat  = 0;
    end else begin
      m_beat++;
    end
  endfunction

  function automatic void model_reset();
    m_stage = 0; m_beat = 0; m_len = 0; m_err = 0;
    got_q.delete();
    exp_q.delete();
  endfunction

  task automatic drive_beat(input in_t d, input logic last);
    int n = 0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && n < 300) begin
      n++;
      @(negedge aclk);
    end
    if (!s_tready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: s_axis_tready=%b required 1", s_tready);
    end
    @(posedge aclk);
    #1;
    if (s_tready === 1'b1 || n < 300) model_beat(d, last);
  endtask

  task automatic send_const(input int n, input int last_at, input logic [DW-1:0] v);
    for (int i = 0; i < n; i++) drive_beat({PN{v}}, i == last_at);
  endtask

  task automatic send_rand(input int n, input int last_at);
    in_t d;
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < PN; l++) d[l*DW +: DW] = DW'($urandom);
      drive_beat(d, i == last_at);
    end
  endtask

  task automatic rand_frame(input int len);
    for (int s = 0; s < FN; s++) send_rand(len, len - 1);
  endtask

  task automatic wait_out();
    int n = 0;
    s_tvalid = 1'b0;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    repeat (4) @(negedge aclk);
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b required 0", s_tready); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b required 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b required 0", m_tlast); end
    n_checks++; if (m_tdata !== '0) begin n_fail++; $display("FAIL rst_tdata: got %h required 0", m_tdata); end
    n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err_len); end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rel_tready_pre: got %b required 0", s_tready); end
    @(posedge aclk);
    #1;
    n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL rel_tready_post: got %b required 1", s_tready); end
  endtask

  task automatic test_fixed(input bit bp);
    beat_t e;
    model_reset();
    bp_en = bp; chk_ready = bp; stab_err = 0; rdy_err = 0;
    send_const(256, 255, 16'h2100);
    send_const(256, 255, 16'h0900);
    send_const(256, 255, 16'h4A00);
    wait_out();
    bp_en = 0; chk_ready = 0;
    n_checks++; if (got_q.size() !== 256) begin n_fail++; $display("FAIL fixed_count: got %0d required 256", got_q.size()); end
    foreach (got_q[i]) begin
      e.last = (i == 255);
      e.data = {PN{AWD'(24'h084A00)}};
      n_checks++;
      if (got_q[i] !== e) begin n_fail++; $display("FAIL fixed_beat%0d: got %h required %h", i, got_q[i], e); end
    end
    n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL fixed_err: got %b required 0", err_len); end
    if (bp) begin
      n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable beats required 0", stab_err); end
      n_checks++; if (rdy_err !== 0) begin n_fail++; $display("FAIL bp_tready: got %0d mismatches required 0", rdy_err); end
    end
  endtask

  task automatic test_clamp();
    beat_t e;
    model_reset();
    send_const(4, 3, 16'h0000);
    send_const(4, 3, 16'hF000);
    send_const(4, 3, 16'h0000);
    wait_out();
    n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL clamp_count: got %0d required 4", got_q.size()); end
    foreach (got_q[i]) begin
      e.last = (i == 3);
      e.data = '0;
      n_checks++;
      if (got_q[i] !== e) begin n_fail++; $display("FAIL clamp_beat%0d: got %h required %h", i, got_q[i], e); end
    end
  endtask

  task automatic test_model(input string name);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_beat%0d: got %h required %h", name, i, got_q[i], exp_q[i]); end
      end
    end
    n_checks++; if (err_len !== m_err) begin n_fail++; $display("FAIL %s_err: got %b required %b", name, err_len, m_err); end
  endtask

  task automatic test_back_to_back();
    model_reset();
    rand_frame(20);
    rand_frame(1);
    rand_frame(33);
    wait_out();
    test_model("b2b");
  endtask

  task automatic test_random();
    int g;
    model_reset();
    for (int f = 0; f < 6; f++) begin
      int len;
      len = (f == 0) ? 1 : int'($urandom_range(1, 40));
      bp_en = 1'($urandom_range(0, 1));
      for (int s = 0; s < FN; s++) begin
        send_rand(len, len - 1);
        g = int'($urandom_range(0, 3));
        s_tvalid = 1'b0;
        repeat (g) begin @(posedge aclk); #1; end
      end
    end
    wait_out();
    bp_en = 0;
    test_model("rand");
  endtask

  task automatic test_len_error();
    model_reset();
    n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL lerr_pre: got %b required 0", err_len); end
    send_rand(256, 255);
    send_rand(200, 199);
    n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL lerr_set: got %b required 1", err_len); end
    send_rand(256, 255);
    rand_frame(16);
    wait_out();
    test_model("lerr");
    n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL lerr_sticky: got %b required 1", err_len); end
  endtask

  task automatic test_mid_reset();
    model_reset();
    send_rand(256, 255);
    send_rand(100, -1);
    s_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL mrst_tready: got %b required 0", s_tready); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mrst_tvalid: got %b required 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL mrst_tlast: got %b required 0", m_tlast); end
    n_checks++; if (m_tdata !== '0) begin n_fail++; $display("FAIL mrst_tdata: got %h required 0", m_tdata); end
    n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL mrst_err: got %b required 0", err_len); end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    model_reset();
    rand_frame(64);
    wait_out();
    test_model("mrst");
  endtask

  task automatic test_excess();
    model_reset();
    send_rand(10, 9);
    send_rand(14, 13);
    send_rand(10, 9);
    wait_out();
    test_model("excess");
    n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL excess_err: got %b required 1", err_len); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_rand(515, 514);
    n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b required 1", err_len); end
    send_rand(512, 511);
    send_rand(512, 511);
    wait_out();
    test_model("ovf");
  endtask

  initial begin
    test_reset();
    test_fixed(1'b0);
    test_fixed(1'b1);
    test_clamp();
    test_back_to_back();
    test_random();
    test_len_error();
    test_mid_reset();
    test_excess();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
